// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deser
//  Purpose  : UART receive front-end. Synchronises the rx line, oversamples it
//             on the shared baud tick, deframes LSB-first bytes and buffers
//             them in a first-word-fall-through FIFO.
//  Options  : define UART_RX_PARITY_EN to receive an even-parity bit between
//             the data bits and the stop bit (8E1); otherwise 8N1.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_deser #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_tick,
    input  logic                          i_rx,
    input  logic                          i_rd_en,
    output logic [DATA_W-1:0]             o_data_out,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_ack,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overrun,
    output logic [2:0]                    o_state_rx
);

    localparam int C_CNT_W = $clog2(OVERSAMPLE);
    localparam int C_BIT_W = $clog2(DATA_W);
    localparam int C_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [C_CNT_W-1:0] C_HALF_M1  = C_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [C_CNT_W-1:0] C_FULL_M1  = C_CNT_W'(OVERSAMPLE - 1);
    localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(DATA_W - 1);
    localparam logic [C_PTR_W:0]   C_CNT_FULL = (C_PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_armed;       // line has been seen high since last frame
    logic [C_CNT_W-1:0]  r_tick_cnt;
    logic [C_BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_ack;
    logic                r_frame_err;
    logic                r_overrun;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic [C_PTR_W:0]    r_count;

    logic                w_par_bad;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

`ifdef UART_RX_PARITY_EN
    logic                r_par_bad;
    logic                r_parity_err;
    assign w_par_bad    = r_par_bad;
    assign o_parity_err = r_parity_err;
`else
    assign w_par_bad    = 1'b0;
    assign o_parity_err = 1'b0;
`endif

    // A full FIFO can still accept the byte when the head is popped in the same cycle
    assign w_full = (r_count == C_CNT_FULL);
    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_push = (r_state == S_STOP) && i_tick && (r_tick_cnt == C_FULL_M1) &&
                    r_rx_sync && !w_par_bad && (!w_full || w_pop);

    // Two-flop synchroniser for the asynchronous rx line, idle-high at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Frame deserialiser FSM with registered one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_ack        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_ack        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (i_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_rx_sync) begin
                            r_armed <= 1'b1;
                        end else if (r_armed) begin
                            r_state    <= S_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        if (r_tick_cnt == C_HALF_M1) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            // A start bit that is gone by mid-bit was a glitch
                            r_state    <= r_rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_tick_cnt == C_FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_sync, r_shift[DATA_W-1:1]};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (r_tick_cnt == C_FULL_M1) begin
                            r_tick_cnt <= '0;
                            // Even parity: received bit must equal XOR of the data bits
                            r_par_bad  <= (^r_shift) ^ r_rx_sync;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_tick_cnt == C_FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_IDLE;
                            if (!r_rx_sync) begin
                                r_frame_err <= 1'b1;
                                r_armed     <= 1'b0;
                            end
`ifdef UART_RX_PARITY_EN
                            else if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end
`endif
                            else if (w_push) begin
                                r_ack <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_data_out  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;
    assign o_ack       = r_ack;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_state_rx  = r_state;

endmodule
`default_nettype wire
